md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu/madd/maddu/msub/msubu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, E-stage MDU instruction valid this cycle and not stalled.
REQ-006 SHALL have port md_op, input, 4, operation code taken from the shared constants.
REQ-007 SHALL have port A, input, 32, forwarded rs operand.
REQ-008 SHALL have port B, input, 32, forwarded rt operand.
REQ-009 SHALL have port D_md, input, 1, D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo/madd family).
REQ-010 SHALL have port busy, output, 1, multi-cycle operation in progress.
REQ-011 SHALL have port md_stall, output, 1, stall request to the hazard unit.
REQ-012 SHALL have port HI, output, 32, architectural HI register.
REQ-013 SHALL have port LO, output, 32, architectural LO register.

Function
REQ-014 SHALL implement states IDLE, MULT, DIV; busy = (state != IDLE).
REQ-015 SHALL, in IDLE on an edge with start=1 and a mult-family op, compute the result from A/B, hold it in shadow registers, load the counter with MULT_CYCLES and enter MULT.
REQ-016 SHALL, in IDLE on an edge with start=1 and div/divu, compute the result, hold it, load the counter with DIV_CYCLES and enter DIV.
REQ-017 SHALL decrement the counter on each edge in MULT/DIV; on the edge where the counter equals 1 it SHALL write the shadow results to HI/LO and return to IDLE, so busy is high for exactly N cycles and new HI/LO are visible in the first cycle with busy=0.
REQ-018 SHALL, in IDLE on an edge with start=1 and mthi (mtlo), write A to HI (LO) on that edge, stay IDLE, and never assert busy.
REQ-019 SHALL treat unknown md_op with start=1 as a no-op.
REQ-020 SHALL ignore start while busy; HI/LO and the counter are unaffected.
REQ-021 SHALL drive md_stall = D_md & (busy | start), combinationally.
REQ-022 SHALL compute mult/multu as the full 64-bit signed/unsigned product, HI = bits 63:32, LO = bits 31:0.
REQ-023 SHALL compute div signed with quotient truncated toward zero in LO and remainder in HI carrying the dividend's sign; divu unsigned.
REQ-024 SHALL, for div with A=0x80000000, B=0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-025 SHALL, for B=0 on div/divu, still run DIV_CYCLES busy cycles and leave HI/LO unchanged at completion.

Reset
REQ-026 SHALL, on reset assertion (at any time, including mid-operation), immediately force state IDLE, counter 0, busy 0, HI 0, LO 0 and discard pending shadow results.
REQ-027 SHALL keep md_stall = D_md & start while reset is high.

Configuration
REQ-028 SHALL compile madd/maddu/msub/msubu only when MD_SEQUENCER_MADD_EN is defined: {HI,LO} = {HI,LO} +/- signed/unsigned 64-bit product, sampled from HI/LO at the start edge, MULT_CYCLES latency.
REQ-029 SHALL, without MD_SEQUENCER_MADD_EN, treat those four codes as no-ops per REQ-019.

Structure
REQ-030 SHALL take md_op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9) and the state encoding from the team's shared constants header.
REQ-031 SHALL place the combinational 64-bit arithmetic in one sub-module md_arith; md_sequencer holds the FSM, counter, shadow registers and HI/LO.

Verification
REQ-032 SHALL cover: mult A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> HI/LO unchanged after 10 cycles.
REQ-034 SHALL cover: mthi A=0x12345678 -> HI=0x12345678 next cycle, busy never 1; D_md=1 during any busy cycle -> md_stall=1; D_md=0 -> md_stall=0.
REQ-035 SHALL cover: second start during busy cycle 3 of a mult -> ignored, completion at original cycle with first result.
REQ-036 SHALL cover: reset pulse in DIV cycle 4 -> busy, HI, LO all 0 immediately; no later write occurs.
REQ-037 SHALL cover, with MD_SEQUENCER_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro -> no change, busy stays 0.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared md_op encodings, FSM states and the arithmetic result bundle.
// madd/msub codes are only decoded when MD_SEQUENCER_MADD_EN is defined.
package md_sequencer_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide datapath for the MDU sequencer.
// Accumulate ops (MD_SEQUENCER_MADD_EN) add HI/LO inputs to the datapath.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
`ifdef MD_SEQUENCER_MADD_EN
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
`endif
  output md_res_t     res_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] ua, ub, ubs;
  logic [31:0] sq, sr;
  logic [31:0] bus;
  logic [31:0] uq, ur;
`ifdef MD_SEQUENCER_MADD_EN
  logic [63:0] acc;
  logic [63:0] sum;
`endif

  always_comb begin
    // Sign-extended operands give the signed product in the low 64 bits
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u = {32'd0, a_i} * {32'd0, b_i};

    ua  = a_i[31] ? -a_i : a_i;
    ub  = b_i[31] ? -b_i : b_i;
    ubs = (ub == 32'd0) ? 32'd1 : ub;
    sq  = ua / ubs;
    sr  = ua % ubs;
    if (a_i[31] ^ b_i[31]) sq = -sq;
    if (a_i[31]) sr = -sr;

    bus = (b_i == 32'd0) ? 32'd1 : b_i;
    uq  = a_i / bus;
    ur  = a_i % bus;

`ifdef MD_SEQUENCER_MADD_EN
    acc = {hi_i, lo_i};
    sum = 64'd0;
`endif

    res_o = '0;
    case (op_i)
      OP_MULT:  res_o = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
      OP_MULTU: res_o = '{wr: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
      OP_DIV:   res_o = '{wr: (b_i != 32'd0), hi: sr, lo: sq};
      OP_DIVU:  res_o = '{wr: (b_i != 32'd0), hi: ur, lo: uq};
`ifdef MD_SEQUENCER_MADD_EN
      OP_MADD: begin
        sum   = acc + prod_s;
        res_o = '{wr: 1'b1, hi: sum[63:32], lo: sum[31:0]};
      end
      OP_MADDU: begin
        sum   = acc + prod_u;
        res_o = '{wr: 1'b1, hi: sum[63:32], lo: sum[31:0]};
      end
      OP_MSUB: begin
        sum   = acc - prod_s;
        res_o = '{wr: 1'b1, hi: sum[63:32], lo: sum[31:0]};
      end
      OP_MSUBU: begin
        sum   = acc - prod_u;
        res_o = '{wr: 1'b1, hi: sum[63:32], lo: sum[31:0]};
      end
`endif
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// MDU sequencer: FSM, busy counter, shadow results and HI/LO registers.
// Define MD_SEQUENCER_MADD_EN to enable madd/maddu/msub/msubu.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  md_res_t     sh_q;
  md_res_t     res;
  logic [31:0] hi_q, lo_q;
  logic        is_mul, is_div, is_mthi, is_mtlo;

  md_arith u_arith (
    .op_i  (md_op),
    .a_i   (A),
    .b_i   (B),
`ifdef MD_SEQUENCER_MADD_EN
    .hi_i  (hi_q),
    .lo_i  (lo_q),
`endif
    .res_o (res)
  );

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (md_op == OP_MULT),
      (md_op == OP_MULTU): is_mul = 1'b1;
`ifdef MD_SEQUENCER_MADD_EN
      (md_op == OP_MADD),
      (md_op == OP_MADDU),
      (md_op == OP_MSUB),
      (md_op == OP_MSUBU): is_mul = 1'b1;
`endif
      (md_op == OP_DIV),
      (md_op == OP_DIVU):  is_div = 1'b1;
      (md_op == OP_MTHI):  is_mthi = 1'b1;
      (md_op == OP_MTLO):  is_mtlo = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              sh_q    <= res;
              cnt_q   <= CW'(MULT_CYCLES);
              state_q <= ST_MULT;
            end else if (is_div) begin
              sh_q    <= res;
              cnt_q   <= CW'(DIV_CYCLES);
              state_q <= ST_DIV;
            end else if (is_mthi) begin
              hi_q <= A;
            end else if (is_mtlo) begin
              lo_q <= A;
            end
          end
        end
        ST_MULT, ST_DIV: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            // Divide-by-zero leaves wr clear so HI/LO keep their values
            if (sh_q.wr) begin
              hi_q <= sh_q.hi;
              lo_q <= sh_q.lo;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign md_stall = D_md & (busy | start);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: expected completions queued at issue,
// checked by a monitor when busy drops.
module tb_md_sequencer;

  localparam logic [3:0] C_MULT  = 4'd0;
  localparam logic [3:0] C_MULTU = 4'd1;
  localparam logic [3:0] C_DIV   = 4'd2;
  localparam logic [3:0] C_DIVU  = 4'd3;
  localparam logic [3:0] C_MTHI  = 4'd4;
  localparam logic [3:0] C_MTLO  = 4'd5;
  localparam logic [3:0] C_MADDU = 4'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        D_md;
  logic        busy, md_stall;
  logic [31:0] HI, LO;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .D_md     (D_md),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles, compares on each completion
  initial begin : monitor
    bit prev = 1'b0;
    int run  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (busy) run++;
        if (prev && !busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion len=%0d want=none", run);
          end else begin
            e = sb.pop_front();
            chk("busy_len", 32'(run), 32'(e.len));
            chk("done_HI", HI, e.hi);
            chk("done_LO", LO, e.lo);
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    step(1);
    start = 1'b0;
  endtask

  task automatic push(input int len, input logic [31:0] hi,
                      input logic [31:0] lo);
    exp_t e;
    e.len = len;
    e.hi  = hi;
    e.lo  = lo;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string nm, input logic stall_exp);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) chk({nm, "_stall"}, 32'(md_stall), 32'(stall_exp));
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=busy want=idle", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic never_busy(input string nm, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk({nm, "_never_busy"}, 32'(seen), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    start = 1'b0;
    md_op = 4'd0;
    A     = '0;
    B     = '0;
    D_md  = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    D_md  = 1'b1;
    start = 1'b1;
    #1;
    chk("rst_stall_start", 32'(md_stall), 32'd1);
    start = 1'b0;
    #1;
    chk("rst_stall_nostart", 32'(md_stall), 32'd0);
    D_md  = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    // signed mult with D_md high while busy
    push(5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(C_MULT, 32'hFFFF_FFFE, 32'd3);
    D_md = 1'b1;
    wait_idle("mult", 1'b1);
    D_md = 1'b0;

    push(5, 32'h0000_0002, 32'hFFFF_FFFA);
    issue(C_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle("multu", 1'b0);

    push(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div", 1'b0);

    push(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(C_DIVU, 32'd7, 32'd0);
    wait_idle("divu_zero", 1'b0);

    push(10, 32'h0000_0000, 32'h8000_0000);
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf", 1'b0);

    issue(C_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_HI", HI, 32'h1234_5678);
    chk("mthi_LO", LO, 32'h8000_0000);
    never_busy("mthi", 3);
    issue(C_MTLO, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_LO", LO, 32'hCAFE_F00D);
    chk("mtlo_HI", HI, 32'h1234_5678);

    // second start in busy cycle 3 must be ignored
    push(5, 32'd0, 32'd6);
    issue(C_MULT, 32'd2, 32'd3);
    step(2);
    issue(C_MULT, 32'd5, 32'd5);
    wait_idle("mult_ign", 1'b0);
    never_busy("post_ign", 4);

    issue(4'hF, 32'hDEAD_BEEF, 32'd1);
    never_busy("unknown_op", 3);
    chk("unk_HI", HI, 32'd0);
    chk("unk_LO", LO, 32'd6);

    // reset in div cycle 4 discards the pending result
    issue(C_DIV, 32'd100, 32'd7);
    step(3);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    step(1);
    reset = 1'b0;
    never_busy("after_rst", 12);
    chk("late_HI", HI, 32'd0);
    chk("late_LO", LO, 32'd0);

    issue(C_MTHI, 32'd0, 32'd0);
    issue(C_MTLO, 32'hFFFF_FFFF, 32'd0);
`ifdef MD_SEQUENCER_MADD_EN
    push(5, 32'd1, 32'd0);
    issue(C_MADDU, 32'd1, 32'd1);
    wait_idle("maddu", 1'b0);
`else
    issue(C_MADDU, 32'd1, 32'd1);
    never_busy("maddu_off", 8);
    chk("maddu_off_HI", HI, 32'd0);
    chk("maddu_off_LO", LO, 32'hFFFF_FFFF);
`endif

    step(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
